// File: rtl/ifid_latch.sv
// IF/ID pipeline register: captures fetched instructions, holds on hazard stalls,
// inserts bubbles on misses/flushes and exposes rs/rt/jump/branch to the hazard unit.
module ifid_latch #(
  parameter int unsigned STALL_LIMIT = 255,
  parameter int          CNT_W       = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             prog_en,
  input  logic             flush,
  input  logic             ctrl_resolved,
  input  logic [31:0]      instr_in,
  input  logic [31:0]      pcplus4_in,
  output logic [31:0]      instr_out,
  output logic [31:0]      pcplus4_out,
  output logic             valid,
  output logic [4:0]       ifid_register_rs,
  output logic [4:0]       ifid_register_rt,
  output logic             ifid_jump,
  output logic             ifid_branch,
  output logic [CNT_W-1:0] stall_count,
  output logic             stall_timeout
);

  typedef enum logic [1:0] {EMPTY, LOADED, CTRL_WAIT} state_t;

  state_t           state_p1, state_d;
  logic [31:0]      instr_d, pcplus4_d;
  logic [CNT_W-1:0] cnt_d;

  function automatic logic is_jump(input logic [31:0] instr);
    logic [5:0] op;
    op = instr[31:26];
    return (op == 6'h02) || (op == 6'h03) || ((op == 6'h00) && (instr[5:0] == 6'h08));
  endfunction

  function automatic logic is_branch(input logic [31:0] instr);
    return (instr[31:26] == 6'h04) || (instr[31:26] == 6'h05);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  always_comb begin
    state_d   = state_p1;
    instr_d   = instr_out;
    pcplus4_d = pcplus4_out;
    cnt_d     = stall_count;
    if (flush) begin
      state_d   = EMPTY;
      instr_d   = '0;
      pcplus4_d = '0;
      cnt_d     = '0;
    end else if (!prog_en) begin
      // Held edge: data frozen, but a resolution pulse still retires the pending control op.
      if (state_p1 == CTRL_WAIT && ctrl_resolved) state_d = LOADED;
      if (state_p1 != EMPTY) cnt_d = sat_inc(stall_count);
    end else if (ihit) begin
      state_d   = (is_jump(instr_in) || is_branch(instr_in)) ? CTRL_WAIT : LOADED;
      instr_d   = instr_in;
      pcplus4_d = pcplus4_in;
      cnt_d     = '0;
    end else begin
      state_d   = EMPTY;
      instr_d   = '0;
      pcplus4_d = '0;
      cnt_d     = '0;
    end
  end

  // IF -> ID stage boundary
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_p1    <= EMPTY;
      instr_out   <= '0;
      pcplus4_out <= '0;
      stall_count <= '0;
    end else begin
      state_p1    <= state_d;
      instr_out   <= instr_d;
      pcplus4_out <= pcplus4_d;
      stall_count <= cnt_d;
    end
  end

  assign valid            = (state_p1 != EMPTY);
  assign ifid_register_rs = valid ? instr_out[25:21] : 5'd0;
  assign ifid_register_rt = valid ? instr_out[20:16] : 5'd0;
  assign ifid_jump        = (state_p1 == CTRL_WAIT) && is_jump(instr_out);
  assign ifid_branch      = (state_p1 == CTRL_WAIT) && is_branch(instr_out);
  assign stall_timeout    = (32'(stall_count) >= STALL_LIMIT);

endmodule

// File: tb/tb_ifid_latch.sv
// Bench for ifid_latch: directed vector table, reset/saturation sequences and
// randomized traffic against a behavioural model.
module tb_ifid_latch;

  localparam int LIMIT = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ihit = 1'b0, prog_en = 1'b0, flush = 1'b0, ctrl_resolved = 1'b0;
  logic [31:0] instr_in = '0, pcplus4_in = '0;
  logic [31:0] instr_out, pcplus4_out;
  logic        valid, ifid_jump, ifid_branch, stall_timeout;
  logic [4:0]  ifid_register_rs, ifid_register_rt;
  logic [7:0]  stall_count;

  int compared = 0;
  int mismatched = 0;

  ifid_latch #(.STALL_LIMIT(LIMIT), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .prog_en(prog_en), .flush(flush),
    .ctrl_resolved(ctrl_resolved), .instr_in(instr_in), .pcplus4_in(pcplus4_in),
    .instr_out(instr_out), .pcplus4_out(pcplus4_out), .valid(valid),
    .ifid_register_rs(ifid_register_rs), .ifid_register_rt(ifid_register_rt),
    .ifid_jump(ifid_jump), .ifid_branch(ifid_branch),
    .stall_count(stall_count), .stall_timeout(stall_timeout)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ih, pe, fl, cr;
    logic [31:0] instr;
    logic [31:0] e_instr;
    logic        e_valid;
    logic [4:0]  e_rs, e_rt;
    logic        e_j, e_b;
    logic [7:0]  e_cnt;
    logic        e_to;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic ih, logic pe, logic fl, logic cr, logic [31:0] instr,
                              logic [31:0] e_instr, logic e_valid, logic [4:0] e_rs,
                              logic [4:0] e_rt, logic e_j, logic e_b, logic [7:0] e_cnt,
                              logic e_to);
    vec_t v;
    v.ih = ih; v.pe = pe; v.fl = fl; v.cr = cr; v.instr = instr;
    v.e_instr = e_instr; v.e_valid = e_valid; v.e_rs = e_rs; v.e_rt = e_rt;
    v.e_j = e_j; v.e_b = e_b; v.e_cnt = e_cnt; v.e_to = e_to;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic ih, input logic pe, input logic fl, input logic cr,
                       input logic [31:0] instr, input logic [31:0] pc);
    ihit = ih; prog_en = pe; flush = fl; ctrl_resolved = cr;
    instr_in = instr; pcplus4_in = pc;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".instr"}, instr_out, 32'd0);
    chk({tag, ".pc"}, pcplus4_out, 32'd0);
    chk({tag, ".valid"}, 32'(valid), 32'd0);
    chk({tag, ".rs"}, 32'(ifid_register_rs), 32'd0);
    chk({tag, ".rt"}, 32'(ifid_register_rt), 32'd0);
    chk({tag, ".jump"}, 32'(ifid_jump), 32'd0);
    chk({tag, ".branch"}, 32'(ifid_branch), 32'd0);
    chk({tag, ".cnt"}, 32'(stall_count), 32'd0);
    chk({tag, ".timeout"}, 32'(stall_timeout), 32'd0);
  endtask

  // Behavioural reference: what the latch should hold, stated directly from the rules.
  logic [31:0] m_instr, m_pc;
  logic        m_valid, m_pend;
  int          m_cnt;

  function automatic logic ref_jump(input logic [31:0] i);
    return (i[31:26] inside {6'h02, 6'h03}) || (i[31:26] == 6'h00 && i[5:0] == 6'h08);
  endfunction

  function automatic logic ref_branch(input logic [31:0] i);
    return i[31:26] inside {6'h04, 6'h05};
  endfunction

  task automatic model_clear();
    m_instr = '0; m_pc = '0; m_valid = 1'b0; m_pend = 1'b0; m_cnt = 0;
  endtask

  task automatic model_edge();
    if (flush) model_clear();
    else if (!prog_en) begin
      if (m_pend && ctrl_resolved) m_pend = 1'b0;
      if (m_valid && m_cnt < 255) m_cnt = m_cnt + 1;
    end else if (ihit) begin
      m_instr = instr_in; m_pc = pcplus4_in; m_valid = 1'b1; m_cnt = 0;
      m_pend = ref_jump(instr_in) || ref_branch(instr_in);
    end else model_clear();
  endtask

  localparam logic [31:0] ADD  = 32'h012A4020;
  localparam logic [31:0] ADD2 = 32'h01095020;
  localparam logic [31:0] BEQ  = 32'h11090004;
  localparam logic [31:0] BNE  = 32'h15280003;
  localparam logic [31:0] JMP  = 32'h08000010;
  localparam logic [31:0] JR   = 32'h03E00008;
  localparam logic [31:0] JUNK = 32'hDEADBEEF;

  initial begin
    logic [31:0] r, ins;
    string tag;

    // Reset state: RST asserted from time 0, sampled before release.
    #7;
    chk_zero("reset");
    RST = 1'b0;

    //           ih pe fl cr instr  e_instr e_v rs  rt  j  b  cnt to
    tbl.push_back(mk(1, 1, 0, 0, ADD,  ADD,  1,  9, 10, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, JUNK, ADD,  1,  9, 10, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, ADD2, ADD,  1,  9, 10, 0, 0, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0, JUNK, ADD,  1,  9, 10, 0, 0, 3, 0));
    tbl.push_back(mk(1, 0, 0, 0, JUNK, ADD,  1,  9, 10, 0, 0, 4, 1));
    tbl.push_back(mk(1, 1, 0, 0, ADD2, ADD2, 1,  8,  9, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, BEQ,  BEQ,  1,  8,  9, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, JUNK, BEQ,  1,  8,  9, 0, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, JUNK, BEQ,  1,  8,  9, 0, 1, 2, 0));
    tbl.push_back(mk(0, 0, 0, 1, JUNK, BEQ,  1,  8,  9, 0, 0, 3, 0));
    tbl.push_back(mk(1, 1, 0, 0, JMP,  JMP,  1,  0,  0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, ADD,  0,    0,  0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, ADD,  ADD,  1,  9, 10, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, JUNK, 0,    0,  0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, ADD,  0,    0,  0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, JR,   JR,   1, 31,  0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, JUNK, 0,    0,  0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, BNE,  BNE,  1,  9,  8, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 1, ADD,  ADD,  1,  9, 10, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].ih, tbl[i].pe, tbl[i].fl, tbl[i].cr, tbl[i].instr, 32'h1000 + 32'(i) * 4);
      step();
      tag = $sformatf("vec%0d", i);
      chk({tag, ".instr"}, instr_out, tbl[i].e_instr);
      chk({tag, ".valid"}, 32'(valid), 32'(tbl[i].e_valid));
      chk({tag, ".rs"}, 32'(ifid_register_rs), 32'(tbl[i].e_rs));
      chk({tag, ".rt"}, 32'(ifid_register_rt), 32'(tbl[i].e_rt));
      chk({tag, ".jump"}, 32'(ifid_jump), 32'(tbl[i].e_j));
      chk({tag, ".branch"}, 32'(ifid_branch), 32'(tbl[i].e_b));
      chk({tag, ".cnt"}, 32'(stall_count), 32'(tbl[i].e_cnt));
      chk({tag, ".timeout"}, 32'(stall_timeout), 32'(tbl[i].e_to));
    end

    // Asynchronous reset in the middle of a branch hold.
    drive(1, 1, 0, 0, BEQ, 32'h2004);
    step();
    drive(0, 0, 0, 0, JUNK, 32'h0);
    step();
    step();
    chk("areset.pre_branch", 32'(ifid_branch), 32'd1);
    #2 RST = 1'b1;
    #1;
    chk_zero("areset");
    step();
    RST = 1'b0;

    // Counter saturation on a long hold, then clear on the next capture.
    drive(1, 1, 0, 0, ADD, 32'h3004);
    step();
    drive(0, 0, 0, 0, JUNK, 32'h0);
    repeat (260) step();
    chk("sat.cnt", 32'(stall_count), 32'd255);
    chk("sat.timeout", 32'(stall_timeout), 32'd1);
    chk("sat.instr", instr_out, ADD);
    chk("sat.pc", pcplus4_out, 32'h3004);
    drive(1, 1, 0, 0, ADD2, 32'h3008);
    step();
    chk("sat.clr_cnt", 32'(stall_count), 32'd0);
    chk("sat.clr_timeout", 32'(stall_timeout), 32'd0);

    // Randomized traffic against the model, starting from a known reset.
    #2 RST = 1'b1;
    #1 RST = 1'b0;
    model_clear();
    for (int n = 0; n < 3000; n++) begin
      r = $urandom;
      case ($urandom_range(0, 5))
        0: ins = $urandom;
        1: ins = {6'h02, r[25:0]};
        2: ins = {6'h03, r[25:0]};
        3: ins = {6'h00, r[25:6], 6'h08};
        4: ins = {6'h04, r[25:0]};
        default: ins = {6'h05, r[25:0]};
      endcase
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 5, $urandom_range(0, 19) == 0,
            $urandom_range(0, 4) == 0, ins, $urandom);
      step();
      model_edge();
      tag = $sformatf("rnd%0d", n);
      chk({tag, ".instr"}, instr_out, m_instr);
      chk({tag, ".pc"}, pcplus4_out, m_pc);
      chk({tag, ".valid"}, 32'(valid), 32'(m_valid));
      chk({tag, ".rs"}, 32'(ifid_register_rs), m_valid ? 32'(m_instr[25:21]) : 32'd0);
      chk({tag, ".rt"}, 32'(ifid_register_rt), m_valid ? 32'(m_instr[20:16]) : 32'd0);
      chk({tag, ".jump"}, 32'(ifid_jump), 32'(m_pend && ref_jump(m_instr)));
      chk({tag, ".branch"}, 32'(ifid_branch), 32'(m_pend && ref_branch(m_instr)));
      chk({tag, ".cnt"}, 32'(stall_count), 32'(m_cnt));
      chk({tag, ".timeout"}, 32'(stall_timeout), 32'(m_cnt >= LIMIT));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ifid_latch.md
# ifid_latch

IF/ID pipeline register that produces the instruction-field view consumed by the hazard unit and obeys that unit's `prog_en`/stall response. It captures fetched instructions on `ihit`, holds them while the hazard unit stalls, inserts bubbles on fetch misses and flushes, and decodes `rs`/`rt`/jump/branch for the hazard check. It tracks unresolved control transfers so the hazard unit's branch/jump stall releases once resolution arrives. It sits between fetch and decode in each core of the dual-core pipeline.

## Interface
- `STALL_LIMIT`, default 255: consecutive held cycles after which `stall_timeout` asserts.
- `CNT_W`, default 8: width of `stall_count`.
- `CLK` input 1: pipeline clock; all state updates on the rising edge.
- `RST` input 1: reset, asynchronous, active-high.
- `ihit` input 1: fetch returned a valid instruction this cycle.
- `prog_en` input 1: hazard unit enable; 0 means hold.
- `flush` input 1: squash IF/ID contents (taken branch or jump from later stage).
- `ctrl_resolved` input 1: single-cycle pulse; the control instruction held in IF/ID is resolved.
- `instr_in` input 32: fetched instruction.
- `pcplus4_in` input 32: PC+4 of fetched instruction.
- `instr_out` output 32: latched instruction (0 = nop).
- `pcplus4_out` output 32: latched PC+4.
- `valid` output 1: latch holds a real instruction.
- `ifid_register_rs` output 5: `instr_out[25:21]`, 0 when `!valid`.
- `ifid_register_rt` output 5: `instr_out[20:16]`, 0 when `!valid`.
- `ifid_jump` output 1: unresolved J/JAL/JR in IF/ID.
- `ifid_branch` output 1: unresolved BEQ/BNE in IF/ID.
- `stall_count` output CNT_W: consecutive held cycles, saturating.
- `stall_timeout` output 1: `stall_count >= STALL_LIMIT`.

## Operation
- FSM states: EMPTY (`valid`=0), LOADED (valid, no pending control), CTRL_WAIT (valid control instruction, `ctrl_pending`=1).
- Per-edge priority: RST > `flush` > (`prog_en`=0: hold) > (`ihit`=1: capture) > (`ihit`=0: bubble).
- Flush: `instr_out`←0, `pcplus4_out`←0, `valid`←0, `ctrl_pending`←0, `stall_count`←0; state→EMPTY. A flush overrides `prog_en`=0.
- Hold: all data registers and state keep their values, except `stall_count`. `ctrl_resolved` is still honoured: in CTRL_WAIT it clears `ctrl_pending` and the state moves to LOADED.
- Capture: load `instr_in` and `pcplus4_in`, `valid`←1, `stall_count`←0. State→CTRL_WAIT if the new instruction is a control transfer, else LOADED.
- Control-transfer decode: opcode `[31:26]` 0x02 or 0x03 is jump; opcode 0x00 with funct `[5:0]` 0x08 is jump (JR); opcode 0x04 or 0x05 is branch.
- Bubble: same effect as flush, except `stall_count`←0 also applies.
- `ifid_jump` = `ctrl_pending` && is_jump(`instr_out`). `ifid_branch` = `ctrl_pending` && is_branch(`instr_out`). Both are combinational from registered state.
- `ctrl_resolved` in EMPTY or LOADED is ignored.
- `stall_count`:
  - Increments by 1 on each edge with `prog_en`=0, `valid`=1 and no flush.
  - Saturates at 2^CNT_W−1.
  - Holds its value on a held edge with `valid`=0.
- `stall_timeout` is a combinational compare. It is a sticky-free status and clears when the counter clears.

## Timing
- Reset values: `instr_out`=0, `pcplus4_out`=0, `valid`=0, `ifid_register_rs`=0, `ifid_register_rt`=0, `ifid_jump`=0, `ifid_branch`=0, `stall_count`=0, `stall_timeout`=0. State is EMPTY.
- Capture latency is 1 cycle: an instruction sampled at edge N appears on the outputs after edge N.
- `ifid_jump`/`ifid_branch` rise in the same cycle `instr_out` shows the control instruction.
- A `ctrl_resolved` pulse at edge N drops `ifid_jump`/`ifid_branch` after edge N, so `prog_en` can return the following cycle.
- Simultaneous `flush` and `ctrl_resolved`: the flush wins and the end state is EMPTY.
- Simultaneous `flush` and `ihit`: the fetched instruction is discarded.
- Asserting RST mid-hold or mid-CTRL_WAIT clears everything immediately, without waiting for a clock edge.

## Test plan
- Reset then capture: assert RST, check every output is 0. Release RST, apply `ihit`=1, `prog_en`=1, `instr_in`=0x012A4020 (add). After 1 edge: `valid`=1, rs=9, rt=10, jump=0, branch=0.
- Hold on stall: with 0x012A4020 latched, hold `prog_en`=0 for 3 edges while `instr_in` changes. Required: `instr_out` unchanged and `stall_count`=3. Then `prog_en`=1 with `ihit`=1: new instruction latched and `stall_count`=0.
- Branch release: capture 0x11090004 (beq), `ifid_branch`=1. Hold `prog_en`=0 for 2 edges, then pulse `ctrl_resolved`. Required: `ifid_branch`=0 after that edge, instruction still latched, state LOADED.
- Flush during stall: latch J 0x08000010 with `prog_en`=0 and assert `flush`. Required: after 1 edge `valid`=0, `instr_out`=0, `ifid_jump`=0.
- Fetch miss: `ihit`=0, `prog_en`=1 for 1 edge after a valid add. Required: bubble with `valid`=0 and rs=rt=0.
- Timeout: with STALL_LIMIT=4, hold a valid instruction for 4 edges. Required: `stall_timeout`=1 after edge 4, and 0 again after the next capture.
